// File: rtl/seven_seg_scanner.sv
// ============================================================================
// seven_seg_scanner
// ----------------------------------------------------------------------------
// Time-multiplexed driver for a common-anode multi-digit seven-segment
// display. One digit is shown per slot of TICK_DIV clock cycles. Digit data is
// double-buffered: a load strobe fills the pending buffer, and the pending
// contents move to the active buffer only at a frame boundary. As a result a
// frame never mixes old and new data.
//
// Optional feature macro: SEVEN_SEG_BRIGHTNESS_EN
//   When defined, a 4-bit brightness input is added. The selected anode is
//   only driven low during the first (brightness+1)/16 of each slot.
//   When undefined, the selected anode is low for the whole slot.
//
// Parameters
//   NUM_DIGITS      number of digits, 2..16
//   TICK_DIV        clock cycles per digit slot, >=16 and a multiple of 16
//
// Ports
//   clock           system clock, all state on the rising edge
//   reset_n         asynchronous active-low reset
//   load            one-cycle strobe that captures digits_in/dp_in as pending
//   digits_in       nibble k is digit k, digit 0 is the rightmost
//   dp_in           decimal point per digit, 1 = lit
//   lz_suppress     1 = blank leading zero digits (digit 0 is never blanked)
//   brightness      (SEVEN_SEG_BRIGHTNESS_EN only) on-time in 1/16 steps
//   anode           active-low digit select, registered
//   cathode         active-low segments {g,f,e,d,c,b,a}, registered
//   dp_n            active-low decimal point, registered
//   update_pending  pending data has not yet reached the active buffer
//   frame_done      one-cycle pulse as the last digit slot ends
// ============================================================================
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 100000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_suppress,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp_n,
    output logic                    update_pending,
    output logic                    frame_done
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0]       tick_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic                    slot_end;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] pending_digits;
    logic [NUM_DIGITS-1:0]   pending_dp;
    logic [4*NUM_DIGITS-1:0] active_digits;
    logic [NUM_DIGITS-1:0]   active_dp;

    logic [3:0]              sel_nibble;
    logic                    sel_dp;
    logic                    sel_blank;
    logic                    zero_run;
    logic                    seg_lit;
    logic [NUM_DIGITS-1:0]   anode_next;
    logic [6:0]              cathode_next;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign slot_end   = (tick_cnt == TICK_LAST);
    assign frame_end  = slot_end && (digit_idx == IDX_LAST);
    assign frame_done = frame_end;

    // Slot timer and digit pointer. digit_idx wraps explicitly so that digit
    // counts that are not a power of two still scan correctly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_end) begin
            tick_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            tick_cnt  <= tick_cnt + 1'b1;
        end
    end

    // Double buffer. A load always lands in pending. At the frame boundary
    // the previous pending contents move to active. A load on that same cycle
    // keeps update_pending set, so its new data waits for the next frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_digits <= '0;
            pending_dp     <= '0;
            active_digits  <= '0;
            active_dp      <= '0;
            update_pending <= 1'b0;
        end else begin
            if (frame_end && update_pending) begin
                active_digits <= pending_digits;
                active_dp     <= pending_dp;
            end
            if (load) begin
                pending_digits <= digits_in;
                pending_dp     <= dp_in;
                update_pending <= 1'b1;
            end else if (frame_end) begin
                update_pending <= 1'b0;
            end
        end
    end

    // Select the current digit and decide on blanking. The scan runs from the
    // most significant digit downwards, and zero_run stays set only while
    // every nibble seen so far is zero. Therefore a digit is blanked exactly
    // when it and all digits above it are zero.
    always_comb begin
        sel_nibble = 4'h0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b0;
        zero_run   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (active_digits[4*k +: 4] == 4'h0);
            if (digit_idx == IDX_W'(k)) begin
                sel_nibble = active_digits[4*k +: 4];
                sel_dp     = active_dp[k];
                sel_blank  = lz_suppress && zero_run && (k != 0);
            end
        end
    end

    // Anode on-time within a slot. The brightness build shortens the on-time
    // in 1/16 steps of the slot.
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    logic [31:0] on_time;
    always_comb begin
        on_time = (32'(brightness) + 32'd1) * 32'(TICK_DIV / 16);
        seg_lit = (32'(tick_cnt) < on_time);
    end
`else
    assign seg_lit = 1'b1;
`endif

    // Next values for the output registers. These are driven from the
    // current digit_idx, so the pins follow the pointer one cycle later.
    always_comb begin
        anode_next = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            anode_next[k] = !(seg_lit && (digit_idx == IDX_W'(k)));
        end
        cathode_next = sel_blank ? 7'b1111111 : hex_to_seg(sel_nibble);
    end

    // Registered pin drivers. Reset forces the display dark.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            anode   <= '1;
            cathode <= 7'b1111111;
            dp_n    <= 1'b1;
        end else begin
            anode   <= anode_next;
            cathode <= cathode_next;
            dp_n    <= ~sel_dp;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ============================================================================
// tb_seven_seg_scanner
// ----------------------------------------------------------------------------
// Testbench for seven_seg_scanner with NUM_DIGITS=4 and TICK_DIV=16.
// At each frame boundary the stimulus side pushes the expected digit slots of
// the next frame, built from a reference model of the buffers. Separately, a
// monitor pops one entry each time the anode pattern switches to a new digit.
// ============================================================================
module tb_seven_seg_scanner;

    localparam int ND = 4;
    localparam int TD = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic          lz_suppress = 1'b0;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    logic [3:0]    brightness = 4'hF;
`endif
    logic [3:0]    anode;
    logic [6:0]    cathode;
    logic          dp_n;
    logic          update_pending;
    logic          frame_done;

    seven_seg_scanner #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .load           (load),
        .digits_in      (digits_in),
        .dp_in          (dp_in),
        .lz_suppress    (lz_suppress),
`ifdef SEVEN_SEG_BRIGHTNESS_EN
        .brightness     (brightness),
`endif
        .anode          (anode),
        .cathode        (cathode),
        .dp_n           (dp_n),
        .update_pending (update_pending),
        .frame_done     (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] cathode;
        logic       dp_n;
    } slot_t;

    slot_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          fd_cyc = 0;
    int          rel_cyc = 0;
    int          prev_fd;
    bit          mon_en = 1'b0;
    logic [3:0]  prev_anode = 4'hF;

    // Reference model of the double buffer
    logic [15:0] m_act_d = '0;
    logic [3:0]  m_act_dp = '0;
    logic [15:0] m_pend_d = '0;
    logic [3:0]  m_pend_dp = '0;
    bit          m_upd = 1'b0;

    always @(posedge clock) cyc++;

    // Expected active-low glyphs, written out by hand, {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue the four slots of the next frame from the model's active buffer
    task automatic push_frame();
        slot_t      e;
        int         hi;
        logic [3:0] nib;
        hi = -1;
        for (int k = 0; k < ND; k++) if (m_act_d[4*k +: 4] != 4'h0) hi = k;
        for (int k = 0; k < ND; k++) begin
            nib       = m_act_d[4*k +: 4];
            e.anode   = ~(4'b0001 << k);
            e.cathode = (lz_suppress && k > hi && k != 0) ? 7'h7F : seg_of(nib);
            e.dp_n    = ~m_act_dp[k];
            exp_q.push_back(e);
        end
    endtask

    // Issue a load strobe, starting from a falling edge
    task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] dp);
        digits_in = d;
        dp_in     = dp;
        load      = 1'b1;
        @(negedge clock);
        load      = 1'b0;
        m_pend_d  = d;
        m_pend_dp = dp;
        m_upd     = 1'b1;
    endtask

    task automatic wait_frame_done();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) check_output("frame_done_timeout", 32'(frame_done), 32'd1);
        fd_cyc = cyc;
    endtask

    // Wait for a frame boundary, optionally load on the frame_done cycle,
    // update the model, and queue the next frame
    task automatic frame_boundary(input bit lz_next, input bit ld,
                                  input logic [15:0] d, input logic [3:0] dp);
        wait_frame_done();
        check_output("upd_at_frame_end", 32'(update_pending), 32'(m_upd));
        if (ld) begin
            digits_in = d;
            dp_in     = dp;
            load      = 1'b1;
        end
        if (m_upd) begin
            m_act_d  = m_pend_d;
            m_act_dp = m_pend_dp;
            m_upd    = 1'b0;
        end
        if (ld) begin
            m_pend_d  = d;
            m_pend_dp = dp;
            m_upd     = 1'b1;
        end
        lz_suppress = lz_next;
        push_frame();
        @(negedge clock);
        load = 1'b0;
        check_output("upd_after_frame", 32'(update_pending), 32'(m_upd));
    endtask

    task automatic check_reset_values();
        check_output("rst_anode", 32'(anode), 32'hF);
        check_output("rst_cathode", 32'(cathode), 32'h7F);
        check_output("rst_dp_n", 32'(dp_n), 32'd1);
        check_output("rst_update_pending", 32'(update_pending), 32'd0);
        check_output("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    // Monitor: a change to a new single-digit anode pattern starts a slot
    always @(negedge clock) begin
        slot_t e;
        if (mon_en && anode !== prev_anode) begin
            prev_anode = anode;
            if (anode !== 4'hF) begin
                if (exp_q.size() == 0) begin
                    check_output("slot_queue_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_output("slot_anode", 32'(anode), 32'(e.anode));
                    check_output("slot_cathode", 32'(cathode), 32'(e.cathode));
                    check_output("slot_dp_n", 32'(dp_n), 32'(e.dp_n));
                end
            end
        end
    end

    initial begin
        $display("[TB] seven_seg_scanner bench start");
        repeat (3) @(negedge clock);
        check_reset_values();
        reset_n = 1'b1;
        rel_cyc = cyc;
        push_frame();
        mon_en = 1'b1;

        // Idle scan of zeros, with first frame latency and frame period
        frame_boundary(1'b0, 1'b0, 16'h0, 4'h0);
        check_output("first_frame_latency", 32'(fd_cyc - rel_cyc), 32'(ND*TD - 1));
        prev_fd = fd_cyc;
        frame_boundary(1'b0, 1'b0, 16'h0, 4'h0);
        check_output("frame_period", 32'(fd_cyc - prev_fd), 32'(ND*TD));

        // Mid-frame load appears on the next frame
        repeat (10) @(negedge clock);
        apply_stimulus(16'h12AF, 4'b0100);
        check_output("upd_after_load", 32'(update_pending), 32'd1);
        frame_boundary(1'b0, 1'b0, 16'h0, 4'h0);

        // A second load overwrites pending
        repeat (5) @(negedge clock);
        apply_stimulus(16'h1111, 4'b0000);
        repeat (3) @(negedge clock);
        apply_stimulus(16'h2222, 4'b0000);
        frame_boundary(1'b0, 1'b0, 16'h0, 4'h0);

        // Leading zero suppression
        repeat (5) @(negedge clock);
        apply_stimulus(16'h0030, 4'b0000);
        frame_boundary(1'b1, 1'b0, 16'h0, 4'h0);
        repeat (5) @(negedge clock);
        apply_stimulus(16'h0000, 4'b1000);
        frame_boundary(1'b1, 1'b0, 16'h0, 4'h0);

        // Load on the frame_done cycle stays pending for one more frame
        repeat (5) @(negedge clock);
        apply_stimulus(16'h5678, 4'b1001);
        frame_boundary(1'b0, 1'b1, 16'h9ABC, 4'b0010);
        frame_boundary(1'b0, 1'b0, 16'h0, 4'h0);

        // Reset during digit 2 with a load pending
        repeat (5) @(negedge clock);
        apply_stimulus(16'h4321, 4'b1111);
        repeat (30) @(negedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_values();
        repeat (2) @(negedge clock);
        reset_n     = 1'b1;
        rel_cyc     = cyc;
        m_act_d     = '0;
        m_act_dp    = '0;
        m_pend_d    = '0;
        m_pend_dp   = '0;
        m_upd       = 1'b0;
        lz_suppress = 1'b0;
        push_frame();
        wait_frame_done();
        check_output("post_reset_latency", 32'(fd_cyc - rel_cyc), 32'(ND*TD - 1));
        check_output("post_reset_upd", 32'(update_pending), 32'd0);
        mon_en = 1'b0;
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 8: digit count, legal 2..16.
REQ-002 Parameter TICK_DIV, default 100000: clock cycles per digit slot (1 ms at 100 MHz), legal >=16, multiple of 16.
REQ-003 clock  in  1  single system clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 load  in  1  one-cycle strobe; captures digits_in/dp_in into the pending buffer.
REQ-006 digits_in  in  4*NUM_DIGITS  nibble k = digit k, k=0 rightmost.
REQ-007 dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-008 lz_suppress  in  1  1 = blank leading zero digits.
REQ-009 anode  out  NUM_DIGITS  active-low digit select, registered.
REQ-010 cathode  out  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-011 dp_n  out  1  active-low decimal point, registered.
REQ-012 update_pending  out  1  high while pending data has not yet reached the active buffer.
REQ-013 frame_done  out  1  one-cycle pulse when the last digit slot ends.

Function
REQ-014 tick_cnt counts 0..TICK_DIV-1 and wraps; slot end = tick_cnt == TICK_DIV-1.
REQ-015 digit_idx advances by 1 at each slot end, wrapping NUM_DIGITS-1 -> 0; frame_done pulses on the slot-end cycle with digit_idx == NUM_DIGITS-1.
REQ-016 Outputs show digit_idx one cycle after it changes (one-cycle registered latency).
REQ-017 Exactly one anode bit (bit digit_idx) is low when the digit is enabled; all others high.
REQ-018 cathode = active-low hex decode of active nibble digit_idx, 0-9 and A-F in standard seven-segment glyphs (b,c,d,E,F lowercase for b,d).
REQ-019 dp_n = ~active_dp[digit_idx].
REQ-020 load captures inputs into pending and sets update_pending; a further load before transfer overwrites pending.
REQ-021 At frame_done, if update_pending, pending -> active and update_pending clears; display never mixes old and new data within a frame.
REQ-022 load on the frame_done cycle: transfer uses pending contents prior to that cycle; new data stays pending, update_pending remains 1.
REQ-023 lz_suppress=1: digits above the highest nonzero active nibble drive cathode 7'b1111111; digit 0 is never blanked; dp_n still follows dp bit.
REQ-024 lz_suppress is sampled continuously (no frame alignment).

Reset
REQ-025 reset_n low: anode all 1, cathode 7'b1111111, dp_n 1, frame_done 0, update_pending 0, tick_cnt 0, digit_idx 0, active and pending buffers 0.
REQ-026 reset_n asserted mid-frame aborts the scan immediately; after release, scan restarts at digit 0 with first slot end TICK_DIV cycles later and pending load discarded.

Configuration
REQ-027 Macro SEVEN_SEG_BRIGHTNESS_EN defined: input brightness [3:0] added; selected anode low only while tick_cnt < (brightness+1)*(TICK_DIV/16), high otherwise; cathode/dp_n unaffected.
REQ-028 Macro undefined: no brightness port; anode low for the full slot (equivalent to brightness=15).

Verification (NUM_DIGITS=4, TICK_DIV=16)
REQ-029 Reset release, no load -> anode cycles 1110,1101,1011,0111 every 16 cycles, cathode 7'b1000000 ("0"), frame_done every 64 cycles.
REQ-030 load digits_in=16'h12AF, dp_in=4'b0100 mid-frame -> update_pending=1 until frame_done; next frame shows F,A,2,1 with dp_n=0 only on digit 2.
REQ-031 Two loads (16'h1111 then 16'h2222) in one frame -> next frame shows only 2s.
REQ-032 load 16'h0030 with lz_suppress=1 -> digits 3,2 blank, digit 1 "3", digit 0 "0"; digits_in 16'h0000 -> only digit 0 lit.
REQ-033 reset_n pulsed low during digit 2 with pending load -> outputs to reset values immediately; post-release scan starts at digit 0 showing zeros, update_pending=0.
REQ-034 SEVEN_SEG_BRIGHTNESS_EN, brightness=3 -> each anode low 4 of 16 cycles; brightness=15 -> low all 16.
